descrambler_pipe: RTL and testbench
===================================

Name: descrambler_pipe

Overview:
- Parametrised, flow-controlled self-synchronous descrambler for the PCS receive path. Polynomial is x^58 + x^39 + 1.
- Sits between block-lock/gearbox output and the 64b/66b decoder.
- Adds the following over the fixed 64-bit descrambler:
  - configurable data width;
  - valid/ready handshake with a registered output;
  - sync-header pass-through;
  - per-beat bypass;
  - synchronous flush;
  - a "primed" flag marking when the output is trustworthy.

Parameters:
- DATA_W, 64, payload bits per beat; legal range 8..128.
- HDR_W, 2, sync-header bits carried alongside the payload, unmodified.
- SEED, 58'h0, state value loaded on reset and on flush.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous; clears scrambler state and pipeline (e.g. on block-lock loss).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  scrambled payload; bit 0 is first on the wire.
- in_hdr  in  HDR_W  sync header; passed through unchanged.
- in_bypass  in  1  when 1, this beat's payload is passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  DATA_W  descrambled payload.
- out_hdr  out  HDR_W  header registered alongside out_data.
- out_primed  out  1  1 when every bit of out_data was computed from received bits rather than SEED.

Behaviour:
- Reset: state=SEED, out_valid=0, out_data=0, out_hdr=0, out_primed=0, prime counter=0.
- in_ready = !flush && (!out_valid || out_ready). This is a single output register with no extra buffering. The combinational path from out_ready to in_ready is permitted.
- Accept (in_valid && in_ready):
  - Process bits i = 0..DATA_W-1 serially within one cycle: out[i] = d[i] ^ s[57] ^ s[38], then s = {s[56:0], d[i]}.
  - Register the result, in_hdr and the primed flag. out_valid=1 on the next edge. Latency is one cycle.
- State update uses the received (scrambled) bits regardless of in_bypass, so toggling bypass never desynchronises the stream.
- When in_bypass=1, out_data=in_data.
- State and prime counter change only on accepted beats. Stalls (in_valid=0 or backpressure) hold everything.
- Output hold: if out_valid && !out_ready, out_data, out_hdr and out_primed are stable. If out_ready=1 with no new accept, out_valid falls to 0.
- Prime counter:
  - PRIME_BEATS = ceil(58/DATA_W).
  - The counter counts accepted beats and saturates at PRIME_BEATS.
  - The registered out_primed for a beat = (counter value before that beat's accept >= PRIME_BEATS).
  - DATA_W=64: beat 0 is unprimed, beat 1 onward is primed. DATA_W=32: beats 0 and 1 are unprimed, beat 2 onward is primed.
- Flush (priority over accept):
  - The beat presented in the flush cycle is not accepted.
  - Next edge: state=SEED, counter=0, out_valid=0. Any held output beat is discarded.
- Reset mid-transfer: the in-flight beat is lost and all outputs return to reset values.

Decomposition:
- pcs_pkg holds:
  - SCR_LEN=58, SCR_TAP=39;
  - function scr_prime_beats(width);
  - typedef scr_state_t (logic [SCR_LEN-1:0]).
- One natural sub-module, descrambler_core: pure combinational DATA_W-bit unrolled descramble. Inputs are state and data; outputs are out and next_state. The same core is reused by a future scrambler-check/PRBS monitor.
- Handshake, prime counter and flush logic stay in the top module.

Test Plan:
- DATA_W=64, after reset, feed in_data=64'h1 then 64'h0, out_ready=1 -> out_data 64'h0400_0080_0000_0001 (out_primed=0), then 64'h0 (out_primed=1).
- Scrambler model drives random payloads through the DUT at DATA_W=64, 32 and 66 -> output equals the original from beat PRIME_BEATS onward. out_primed rises exactly at beat PRIME_BEATS (1, 2, 1 respectively).
- Random in_valid and out_ready stalls with 2000 beats -> no beat lost or duplicated. Output is stable while stalled. Output matches the no-stall run bit for bit.
- Set in_bypass=1 on beat 5 only -> beat 5 out_data = in_data. Beats 6+ are still correctly descrambled.
- Assert flush while out_valid && !out_ready -> next cycle out_valid=0 and in_ready=1. Re-feeding the stream from the 64'h1 vector reproduces the first scenario's outputs exactly.
- Assert reset asynchronously mid-stall -> out_valid, out_data and out_primed are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared PCS definitions: descrambler polynomial x^58 + x^39 + 1 and the
// helpers that size its pipeline bookkeeping.
package pcs_pkg;

  localparam int SCR_LEN = 58;
  localparam int SCR_TAP = 39;

  typedef logic [SCR_LEN-1:0] scr_state_t;

  // Beats needed before every state bit has come from received data.
  function automatic int scr_prime_beats(input int width);
    return (SCR_LEN + width - 1) / width;
  endfunction

endpackage

// File: rtl/descrambler_core.sv
// Combinational DATA_W-bit unrolled self-synchronous descrambler step.
// Bit 0 of data_i is the first bit on the wire.
module descrambler_core
  import pcs_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  scr_state_t        state_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output scr_state_t        next_state_o
);

  always_comb begin
    scr_state_t s;
    // NOTE: blocking assignments are intentional: s is a chained temporary
    // that each unrolled bit step must see already updated.
    s      = state_i;
    data_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_o[i] = data_i[i] ^ s[SCR_LEN-1] ^ s[SCR_TAP-1];
      s         = {s[SCR_LEN-2:0], data_i[i]};
    end
    next_state_o = s;
  end

endmodule

// File: rtl/descrambler_pipe.sv
// Flow-controlled PCS receive descrambler: one registered output stage with
// sync-header pass-through, per-beat bypass, synchronous flush and a primed flag.
module descrambler_pipe
  import pcs_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter int         HDR_W  = 2,
  parameter scr_state_t SEED   = 58'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [HDR_W-1:0]  in_hdr,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [HDR_W-1:0]  out_hdr,
  output logic              out_primed
);

  localparam int PRIME_BEATS = scr_prime_beats(DATA_W);
  localparam int CNT_W       = $clog2(PRIME_BEATS + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t PRIME_CNT = cnt_t'(PRIME_BEATS);

  scr_state_t        state_q, state_d, core_state;
  cnt_t              cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d, core_data;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic              primed_q, primed_d;
  logic              accept;

  descrambler_core #(.DATA_W(DATA_W)) u_core (
    .state_i      (state_q),
    .data_i       (in_data),
    .data_o       (core_data),
    .next_state_o (core_state)
  );

  // Single output register: a new beat may enter only as the held one leaves.
  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    hdr_d    = hdr_q;
    primed_d = primed_q;
    if (flush) begin
      state_d = SEED;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      // State always follows the received bits so bypass never desynchronises.
      state_d  = core_state;
      valid_d  = 1'b1;
      data_d   = in_bypass ? in_data : core_data;
      hdr_d    = in_hdr;
      primed_d = (cnt_q >= PRIME_CNT);
      if (cnt_q != PRIME_CNT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: every register, datapath included, is asynchronously reset so that
  // all outputs read as zero the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEED;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      hdr_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      hdr_q    <= hdr_d;
      primed_q <= primed_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_hdr    = hdr_q;
  assign out_primed = primed_q;

endmodule

// File: tb/tb_descrambler_pipe.sv
// Bench for descrambler_pipe at DATA_W = 64, 32 and 66 against a bit-stream
// reference model of the x^58 + x^39 + 1 scrambler/descrambler pair.
module tb_descrambler_pipe;

  localparam logic [57:0] SEED = 58'h0;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        v64, r64, b64, ov64, or64, p64;
  logic [63:0] d64, od64;
  logic [1:0]  h64, oh64;
  logic        v32, r32, b32, ov32, or32, p32;
  logic [31:0] d32, od32;
  logic [1:0]  h32, oh32;
  logic        v66, r66, b66, ov66, or66, p66;
  logic [65:0] d66, od66;
  logic [1:0]  h66, oh66;

  descrambler_pipe #(.DATA_W(64), .HDR_W(2), .SEED(SEED)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v64), .in_ready(r64), .in_data(d64), .in_hdr(h64), .in_bypass(b64),
    .out_valid(ov64), .out_ready(or64), .out_data(od64), .out_hdr(oh64), .out_primed(p64)
  );

  descrambler_pipe #(.DATA_W(32), .HDR_W(2), .SEED(SEED)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v32), .in_ready(r32), .in_data(d32), .in_hdr(h32), .in_bypass(b32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_hdr(oh32), .out_primed(p32)
  );

  descrambler_pipe #(.DATA_W(66), .HDR_W(2), .SEED(SEED)) u_dut66 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(v66), .in_ready(r66), .in_data(d66), .in_hdr(h66), .in_bypass(b66),
    .out_valid(ov66), .out_ready(or66), .out_data(od66), .out_hdr(oh66), .out_primed(p66)
  );

  // ---------------- reference model ----------------
  bit          rx_hist[$];   // every received (scrambled) bit since reset/flush
  int          rx_beats;
  bit          tx_hist[$];   // scrambler output history
  logic [57:0] tx_init;      // scrambler bits before its first output

  logic [127:0] plain_a [0:1999];
  logic [127:0] scr_a   [0:1999];
  logic [1:0]   hdr_a   [0:1999];

  function automatic logic [127:0] wmask(input int w);
    return {128{1'b1}} >> (128 - w);
  endfunction

  function automatic int prime_of(input int w);
    return (58 + w - 1) / w;
  endfunction

  function automatic bit rx_bit(input int idx);
    return (idx < 0) ? SEED[-idx-1] : rx_hist[idx];
  endfunction

  function automatic bit tx_bit(input int idx);
    return (idx < 0) ? tx_init[-idx-1] : tx_hist[idx];
  endfunction

  // Descrambled bit n = c[n] ^ c[n-39] ^ c[n-58] over the received stream.
  function automatic void ref_beat(input int w, input logic [127:0] d, input bit byp,
                                   output logic [127:0] o, output bit primed);
    int n;
    o      = '0;
    primed = (rx_beats >= prime_of(w));
    for (int i = 0; i < w; i++) begin
      n    = rx_hist.size();
      o[i] = byp ? d[i] : (d[i] ^ rx_bit(n - 39) ^ rx_bit(n - 58));
      rx_hist.push_back(d[i]);
    end
    rx_beats++;
  endfunction

  function automatic void gen_stream(input int w, input int n);
    logic [63:0]  t;
    logic [127:0] p, c;
    int           m;
    t = {$urandom(), $urandom()};
    tx_init = t[57:0];
    tx_hist.delete();
    for (int k = 0; k < n; k++) begin
      p = {$urandom(), $urandom(), $urandom(), $urandom()} & wmask(w);
      c = '0;
      for (int i = 0; i < w; i++) begin
        m    = tx_hist.size();
        c[i] = p[i] ^ tx_bit(m - 39) ^ tx_bit(m - 58);
        tx_hist.push_back(c[i]);
      end
      plain_a[k] = p;
      scr_a[k]   = c;
      hdr_a[k]   = 2'($urandom_range(0, 3));
    end
  endfunction

  // ---------------- DUT access helpers ----------------
  task automatic set_in(input int w, input logic v, input logic [127:0] d,
                        input logic [1:0] h, input logic b, input logic ordy);
    case (w)
      32:      begin v32 = v; d32 = d[31:0]; h32 = h; b32 = b; or32 = ordy; end
      66:      begin v66 = v; d66 = d[65:0]; h66 = h; b66 = b; or66 = ordy; end
      default: begin v64 = v; d64 = d[63:0]; h64 = h; b64 = b; or64 = ordy; end
    endcase
  endtask

  function automatic logic get_ready(input int w);
    case (w)
      32:      return r32;
      66:      return r66;
      default: return r64;
    endcase
  endfunction

  task automatic get_out(input int w, output logic v, output logic [127:0] d,
                         output logic [1:0] h, output logic p);
    case (w)
      32:      begin v = ov32; d = 128'(od32); h = oh32; p = p32; end
      66:      begin v = ov66; d = 128'(od66); h = oh66; p = p66; end
      default: begin v = ov64; d = 128'(od64); h = oh64; p = p64; end
    endcase
  endtask

  task automatic restart();
    set_in(32, 1'b0, '0, 2'b00, 1'b0, 1'b1);
    set_in(64, 1'b0, '0, 2'b00, 1'b0, 1'b1);
    set_in(66, 1'b0, '0, 2'b00, 1'b0, 1'b1);
    flush = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rx_hist.delete();
    rx_beats = 0;
  endtask

  // Streams n beats of scr_a through the width-w DUT, optionally with random
  // stalls on both sides, checking every delivered beat and every stalled cycle.
  task automatic run_stream(input int w, input int n, input bit stalls,
                            input int byp_beat, input string tag);
    logic [127:0] exp_d[$];
    bit           exp_p[$];
    logic [1:0]   exp_h[$];
    int           exp_k[$];
    logic [127:0] od, hd, ed, rd;
    logic [1:0]   oh, hh, eh;
    logic         ov, op, hp, v_cur, ordy;
    bit           held, ep, rp;
    int           sent, got, cyc, idx, k;
    sent = 0; got = 0; cyc = 0; held = 0;
    hd = '0; hh = '0; hp = 1'b0;
    while (got < n && cyc < 20 * n + 100) begin
      idx   = (sent < n) ? sent : 0;
      v_cur = (sent < n) && (!stalls || $urandom_range(0, 3) != 0);
      ordy  = !stalls || $urandom_range(0, 2) != 0;
      set_in(w, v_cur, scr_a[idx], hdr_a[idx], sent == byp_beat, ordy);
      @(negedge clk);
      get_out(w, ov, od, oh, op);
      if (held) begin
        checks++;
        if (ov !== 1'b1 || od !== hd || oh !== hh || op !== hp) begin
          failures++;
          $display("FAIL %s hold: got v=%b d=%h h=%b p=%b expected v=1 d=%h h=%b p=%b",
                   tag, ov, od, oh, op, hd, hh, hp);
        end
      end
      held = ov && !ordy;
      hd = od; hh = oh; hp = op;
      if (ov && ordy) begin
        checks++;
        if (exp_d.size() == 0) begin
          failures++;
          $display("FAIL %s extra beat: got d=%h expected no beat", tag, od);
        end else begin
          ed = exp_d.pop_front(); ep = exp_p.pop_front();
          eh = exp_h.pop_front(); k  = exp_k.pop_front();
          if (od !== ed) begin
            failures++;
            $display("FAIL %s beat %0d data: got %h expected %h", tag, k, od, ed);
          end
          checks++;
          if (op !== ep || oh !== eh) begin
            failures++;
            $display("FAIL %s beat %0d primed/hdr: got %b/%b expected %b/%b",
                     tag, k, op, oh, ep, eh);
          end
          if (k == byp_beat) begin
            checks++;
            if (od !== scr_a[k]) begin
              failures++;
              $display("FAIL %s beat %0d bypass: got %h expected %h", tag, k, od, scr_a[k]);
            end
          end else if (k >= prime_of(w)) begin
            checks++;
            if (od !== plain_a[k]) begin
              failures++;
              $display("FAIL %s beat %0d plaintext: got %h expected %h", tag, k, od, plain_a[k]);
            end
          end
          got++;
        end
      end
      if (v_cur && get_ready(w)) begin
        ref_beat(w, scr_a[idx], sent == byp_beat, rd, rp);
        exp_d.push_back(rd); exp_p.push_back(rp);
        exp_h.push_back(hdr_a[idx]); exp_k.push_back(sent);
        sent++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    set_in(w, 1'b0, '0, 2'b00, 1'b0, 1'b1);
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL %s beat count: got %0d expected %0d (cycle budget expired)", tag, got, n);
    end
  endtask

  // Feeds 64'h1 then 64'h0 from a fresh state and checks the exact outputs.
  task automatic feed_vector(input string tag);
    logic [127:0] od;
    logic [1:0]   oh;
    logic         ov, op;
    set_in(64, 1'b1, 128'h1, 2'b01, 1'b0, 1'b1);
    @(posedge clk);
    #1 set_in(64, 1'b1, 128'h0, 2'b10, 1'b0, 1'b1);
    get_out(64, ov, od, oh, op);
    checks++;
    if ({ov, op, oh, od} !== {1'b1, 1'b0, 2'b01, 128'h0400_0080_0000_0001}) begin
      failures++;
      $display("FAIL %s beat0: got v=%b p=%b h=%b d=%h expected v=1 p=0 h=01 d=04000080_00000001",
               tag, ov, op, oh, od);
    end
    @(posedge clk);
    #1 set_in(64, 1'b0, '0, 2'b00, 1'b0, 1'b1);
    get_out(64, ov, od, oh, op);
    checks++;
    if ({ov, op, oh, od} !== {1'b1, 1'b1, 2'b10, 128'h0}) begin
      failures++;
      $display("FAIL %s beat1: got v=%b p=%b h=%b d=%h expected v=1 p=1 h=10 d=0",
               tag, ov, op, oh, od);
    end
    @(posedge clk);
    #1 get_out(64, ov, od, oh, op);
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL %s drain: got out_valid=%b expected 0", tag, ov);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [127:0] od;
    logic [1:0]   oh;
    logic         ov, op;
    restart();
    get_out(64, ov, od, oh, op);
    checks++;
    if ({ov, op, oh, od} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got v=%b p=%b h=%b d=%h expected all zero", ov, op, oh, od);
    end
    checks++;
    if (r64 !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready: got %b expected 1", r64);
    end
  endtask

  task automatic test_vector();
    restart();
    feed_vector("vector");
  endtask

  task automatic test_widths();
    int ws[3] = '{64, 32, 66};
    foreach (ws[j]) begin
      restart();
      gen_stream(ws[j], 16);
      run_stream(ws[j], 16, 1'b0, -1, $sformatf("width%0d", ws[j]));
    end
  endtask

  task automatic test_back_to_back_stalls();
    restart();
    gen_stream(64, 2000);
    run_stream(64, 2000, 1'b1, -1, "stalls");
  endtask

  task automatic test_bypass();
    restart();
    gen_stream(64, 12);
    run_stream(64, 12, 1'b0, 5, "bypass");
  endtask

  task automatic test_flush();
    restart();
    set_in(64, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'b11, 1'b0, 1'b0);
    @(posedge clk);
    #1 set_in(64, 1'b1, 128'hdead_beef, 2'b01, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (ov64 !== 1'b1 || r64 !== 1'b0) begin
      failures++;
      $display("FAIL flush setup: got out_valid=%b in_ready=%b expected 1/0", ov64, r64);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    set_in(64, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    #1;
    checks++;
    if (ov64 !== 1'b0 || r64 !== 1'b1) begin
      failures++;
      $display("FAIL flush result: got out_valid=%b in_ready=%b expected 0/1", ov64, r64);
    end
    @(posedge clk);
    #1 rx_hist.delete();
    rx_beats = 0;
    feed_vector("flush_refeed");
  endtask

  task automatic test_async_reset();
    restart();
    set_in(64, 1'b1, 128'h1234_5678_9abc_def0, 2'b01, 1'b0, 1'b1);
    @(posedge clk);
    #1 set_in(64, 1'b1, 128'hffff_0000_ffff_0001, 2'b10, 1'b0, 1'b1);
    @(posedge clk);
    #1 set_in(64, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    checks++;
    if (ov64 !== 1'b1 || p64 !== 1'b1 || od64 === 64'h0) begin
      failures++;
      $display("FAIL async setup: got v=%b p=%b d=%h expected v=1 p=1 d nonzero", ov64, p64, od64);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ov64, p64, oh64, od64} !== '0) begin
      failures++;
      $display("FAIL async reset: got v=%b p=%b h=%b d=%h expected all zero",
               ov64, p64, oh64, od64);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_widths();
    test_back_to_back_stalls();
    test_bypass();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
